// File: rtl/axil_blockmem_pkg.sv
// Shared types and constants for the AXI4-Lite to single-port block RAM controller.
package axil_blockmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RWAIT = 3'd4,
        ST_RRESP = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    // Number of byte-offset bits dropped to form a word address.
    function automatic int unsigned byte_shift(input int unsigned data_width);
        return $clog2(data_width / 32'd8);
    endfunction

endpackage

// File: rtl/axil_blockmem_arb.sv
// Two-way round-robin grant between a pending write and a pending read.
// last_grant only moves when the controller actually accepts a request.
module axil_blockmem_arb
    import axil_blockmem_pkg::*;
(
    input  logic clka,
    input  logic rsta,
    input  logic wr_req,
    input  logic rd_req,
    input  logic accept,
    output logic wr_gnt,
    output logic rd_gnt
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant decode; on contention the side not served last time wins.
    always_comb begin
        wr_gnt       = 1'b0;
        rd_gnt       = 1'b0;
        last_grant_d = last_grant_q;
        if (wr_req && rd_req) begin
            if (last_grant_q == GRANT_WR) begin
                rd_gnt = 1'b1;
            end else begin
                wr_gnt = 1'b1;
            end
        end else if (wr_req) begin
            wr_gnt = 1'b1;
        end else if (rd_req) begin
            rd_gnt = 1'b1;
        end else begin
            wr_gnt = 1'b0;
            rd_gnt = 1'b0;
        end
        if (accept) begin
            last_grant_d = rd_gnt ? GRANT_RD : GRANT_WR;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Round-robin history register.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            last_grant_q <= GRANT_WR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/axil_blockmem_ctrl.sv
// AXI4-Lite slave driving one native block-RAM port, one transaction in flight.
// Define AXIL_BLOCKMEM_CTRL_ERR_EN to answer out-of-range addresses with SLVERR.
module axil_blockmem_ctrl
    import axil_blockmem_pkg::*;
#(
    parameter int G_DATAWIDTH     = 32,
    parameter int G_MEMDEPTH      = 1024,
    parameter int G_BWENABLE      = 1,
    parameter int G_AXI_ADDRWIDTH = 32,
    parameter int G_ADDRWIDTH     = $clog2(G_MEMDEPTH),
    parameter int G_WEWIDTH       = (G_DATAWIDTH / 8) * G_BWENABLE + (1 - G_BWENABLE)
) (
    input  logic                       clka,
    input  logic                       rsta,
    input  logic [G_AXI_ADDRWIDTH-1:0] s_axil_awaddr,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [G_DATAWIDTH-1:0]     s_axil_wdata,
    input  logic [G_DATAWIDTH/8-1:0]   s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [G_AXI_ADDRWIDTH-1:0] s_axil_araddr,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [G_DATAWIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic                       mem_en,
    output logic [G_WEWIDTH-1:0]       mem_we,
    output logic [G_ADDRWIDTH-1:0]     mem_addr,
    output logic [G_DATAWIDTH-1:0]     mem_din,
    input  logic [G_DATAWIDTH-1:0]     mem_dout
);

    localparam int unsigned SHIFT_C = byte_shift(G_DATAWIDTH);

    state_t                     state_q, state_d;
    logic                       mem_en_q, mem_en_d;
    logic [G_WEWIDTH-1:0]       mem_we_q, mem_we_d;
    logic [G_ADDRWIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [G_DATAWIDTH-1:0]     mem_din_q, mem_din_d;
    logic [G_DATAWIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic                       bvalid_q, bvalid_d;
    logic                       rvalid_q, rvalid_d;
    logic                       err_q, err_d;

    logic                       idle_s;
    logic                       wr_req_s, rd_req_s;
    logic                       wr_gnt_s, rd_gnt_s;
    logic                       wr_accept_s, rd_accept_s;
    logic [G_AXI_ADDRWIDTH-1:0] addr_s;
    logic [G_AXI_ADDRWIDTH-1:0] word_full_s;
    logic                       addr_err_s;
    logic [G_WEWIDTH-1:0]       we_map_s;
    logic                       unused_addr_s;

    assign idle_s      = (state_q == ST_IDLE);
    assign wr_req_s    = s_axil_awvalid & s_axil_wvalid;
    assign rd_req_s    = s_axil_arvalid;
    assign wr_accept_s = idle_s & wr_req_s & wr_gnt_s & ~rsta;
    assign rd_accept_s = idle_s & rd_req_s & rd_gnt_s & ~rsta;

    axil_blockmem_arb u_arb (
        .clka   (clka),
        .rsta   (rsta),
        .wr_req (wr_req_s),
        .rd_req (rd_req_s),
        .accept (wr_accept_s | rd_accept_s),
        .wr_gnt (wr_gnt_s),
        .rd_gnt (rd_gnt_s)
    );

    // Request address selection, word conversion and write-enable mapping.
    always_comb begin
        addr_s      = wr_gnt_s ? s_axil_awaddr : s_axil_araddr;
        word_full_s = addr_s >> SHIFT_C;
`ifdef AXIL_BLOCKMEM_CTRL_ERR_EN
        addr_err_s  = ({1'b0, word_full_s} >= (G_AXI_ADDRWIDTH + 1)'(G_MEMDEPTH));
`else
        addr_err_s  = 1'b0;
`endif
        if (G_BWENABLE == 1) begin
            we_map_s = G_WEWIDTH'(s_axil_wstrb);
        end else begin
            we_map_s = G_WEWIDTH'(|s_axil_wstrb);
        end
    end

    // Address bits outside the word range only matter for the range check.
    assign unused_addr_s = ^{s_axil_awaddr, s_axil_araddr, word_full_s};

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_d    = state_q;
        mem_en_d   = 1'b0;
        mem_we_d   = {G_WEWIDTH{1'b0}};
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        rdata_d    = rdata_q;
        bresp_d    = bresp_q;
        rresp_d    = rresp_q;
        bvalid_d   = bvalid_q;
        rvalid_d   = rvalid_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_accept_s) begin
                    state_d    = ST_WRITE;
                    mem_en_d   = ~addr_err_s;
                    mem_we_d   = addr_err_s ? {G_WEWIDTH{1'b0}} : we_map_s;
                    mem_addr_d = word_full_s[G_ADDRWIDTH-1:0];
                    mem_din_d  = s_axil_wdata;
                    err_d      = addr_err_s;
                end else if (rd_accept_s) begin
                    state_d    = ST_READ;
                    mem_en_d   = ~addr_err_s;
                    mem_addr_d = word_full_s[G_ADDRWIDTH-1:0];
                    err_d      = addr_err_s;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d  = ST_WRESP;
                bvalid_d = 1'b1;
                bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
            end
            ST_WRESP: begin
                if (s_axil_bready) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                end else begin
                    state_d  = ST_WRESP;
                end
            end
            ST_READ: begin
                state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                state_d  = ST_RRESP;
                rvalid_d = 1'b1;
                rdata_d  = err_q ? {G_DATAWIDTH{1'b0}} : mem_dout;
                rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
            end
            ST_RRESP: begin
                if (s_axil_rready) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b0;
                end else begin
                    state_d  = ST_RRESP;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bvalid_d = 1'b0;
                rvalid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q    <= ST_IDLE;
            mem_en_q   <= 1'b0;
            mem_we_q   <= {G_WEWIDTH{1'b0}};
            mem_addr_q <= {G_ADDRWIDTH{1'b0}};
            mem_din_q  <= {G_DATAWIDTH{1'b0}};
            rdata_q    <= {G_DATAWIDTH{1'b0}};
            bresp_q    <= 2'b00;
            rresp_q    <= 2'b00;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rdata_q    <= rdata_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    assign s_axil_awready = wr_accept_s;
    assign s_axil_wready  = wr_accept_s;
    assign s_axil_arready = rd_accept_s;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign mem_en         = mem_en_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;

endmodule

// File: tb/tb_axil_blockmem_ctrl.sv
// Directed bench for axil_blockmem_ctrl with a behavioural 1-cycle-latency RAM.
module tb_axil_blockmem_ctrl;

    logic        clka = 1'b0;
    logic        rsta;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'h0;

    logic [31:0] ram [0:1023];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clka = ~clka;

    always @(posedge clka) cyc <= cyc + 1;

    // Read-first single-port RAM model.
    always @(posedge clka) begin
        if (mem_en) begin
            mem_dout <= ram[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
            end
        end
    end

    axil_blockmem_ctrl dut (
        .clka(clka), .rsta(rsta),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    endtask

    // Returns at the negedge after the AW/W handshake with valids dropped.
    task automatic wait_wr_hs(output int hs);
        bit done = 1'b0;
        hs = -1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (awready && wready) begin
                hs = cyc; done = 1'b1;
                @(posedge clka); @(negedge clka);
            end else begin
                @(negedge clka);
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL wr_handshake_timeout got=none exp=handshake"); end
    endtask

    task automatic wait_rd_hs(output int hs);
        bit done = 1'b0;
        hs = -1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (arready) begin
                hs = cyc; done = 1'b1;
                @(posedge clka); @(negedge clka);
            end else begin
                @(negedge clka);
            end
        end
        arvalid = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL rd_handshake_timeout got=none exp=handshake"); end
    endtask

    task automatic wait_any_ready();
        bit done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            #1;
            if (arready || awready) done = 1'b1;
            else @(negedge clka);
        end
        total++;
        if (!done) begin bad++; $display("FAIL ready_timeout got=none exp=ready"); end
    endtask

    task automatic test_reset();
        logic [88:0] outs;
        rsta = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (2) @(negedge clka);
        #1;
        outs = {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, mem_en, mem_we, mem_addr, mem_din};
        total++; if (outs !== 89'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs); end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clka); rsta = 1'b0;
        @(negedge clka); #1;
        outs = {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, mem_en, mem_we, mem_addr, mem_din};
        total++; if (outs !== 89'h0) begin bad++; $display("FAIL post_reset_idle got=%h exp=0", outs); end
    endtask

    task automatic test_single_write();
        int h;
        bready = 1'b0;
        start_write(32'h10, 32'hDEADBEEF, 4'hF);
        #1;
        total++; if ({awready, wready} !== 2'b11) begin bad++; $display("FAIL sw_ready got=%b exp=11", {awready, wready}); end
        wait_wr_hs(h);
        total++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'hF, 10'd4}) begin bad++; $display("FAIL sw_strobe got=%b/%h/%0d exp=1/f/4", mem_en, mem_we, mem_addr); end
        total++; if (mem_din !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_din got=%h exp=deadbeef", mem_din); end
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL sw_bvalid_early got=%b exp=0", bvalid); end
        @(negedge clka);
        total++; if ({bvalid, bresp, mem_en, mem_we} !== {1'b1, 2'b00, 1'b0, 4'h0}) begin bad++; $display("FAIL sw_bresp got=%b/%b/%b/%h exp=1/00/0/0", bvalid, bresp, mem_en, mem_we); end
        @(negedge clka);
        total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL sw_bvalid_hold got=%b exp=1", bvalid); end
        bready = 1'b1;
        @(negedge clka);
        total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL sw_bvalid_clear got=%b exp=0", bvalid); end
        total++; if (ram[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_ram got=%h exp=deadbeef", ram[4]); end
    endtask

    task automatic test_byte_readback();
        int h;
        bready = 1'b1; rready = 1'b0;
        start_write(32'h10, 32'h0000AA00, 4'h2);
        wait_wr_hs(h);
        total++; if (mem_we !== 4'h2) begin bad++; $display("FAIL bw_we got=%h exp=2", mem_we); end
        repeat (2) @(negedge clka);
        araddr = 32'h10; arvalid = 1'b1;
        wait_rd_hs(h);
        total++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'h0, 10'd4}) begin bad++; $display("FAIL br_read_en got=%b/%h/%0d exp=1/0/4", mem_en, mem_we, mem_addr); end
        @(negedge clka);
        total++; if ({rvalid, mem_en} !== 2'b00) begin bad++; $display("FAIL br_rwait got=%b exp=00", {rvalid, mem_en}); end
        @(negedge clka);
        total++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'hDEADAAEF}) begin bad++; $display("FAIL br_rdata got=%b/%b/%h exp=1/00/deadaaef", rvalid, rresp, rdata); end
        rready = 1'b1;
        @(negedge clka);
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL br_rvalid_clear got=%b exp=0", rvalid); end
    endtask

    task automatic test_wstrb_zero();
        int h;
        bready = 1'b0;
        start_write(32'h10, 32'hFFFFFFFF, 4'h0);
        wait_wr_hs(h);
        total++; if (mem_we !== 4'h0) begin bad++; $display("FAIL wz_we got=%h exp=0", mem_we); end
        @(negedge clka);
        total++; if ({bvalid, bresp} !== 3'b100) begin bad++; $display("FAIL wz_bresp got=%b/%b exp=1/00", bvalid, bresp); end
        bready = 1'b1;
        @(negedge clka);
        total++; if (ram[4] !== 32'hDEADAAEF) begin bad++; $display("FAIL wz_ram got=%h exp=deadaaef", ram[4]); end
    endtask

    task automatic test_contention();
        int h;
        rsta = 1'b1; @(negedge clka); rsta = 1'b0;
        bready = 1'b1; rready = 1'b1;
        start_write(32'h20, 32'h11111111, 4'hF);
        araddr = 32'h10; arvalid = 1'b1;
        #1;
        total++; if ({arready, awready} !== 2'b10) begin bad++; $display("FAIL ct_first got=%b exp=10", {arready, awready}); end
        @(posedge clka); @(negedge clka);
        wait_any_ready();
        total++; if ({arready, awready} !== 2'b01) begin bad++; $display("FAIL ct_second got=%b exp=01", {arready, awready}); end
        @(posedge clka); @(negedge clka);
        awaddr = 32'h24; wdata = 32'h22222222;
        wait_any_ready();
        total++; if ({arready, awready} !== 2'b10) begin bad++; $display("FAIL ct_third got=%b exp=10", {arready, awready}); end
        @(posedge clka); @(negedge clka);
        arvalid = 1'b0;
        wait_wr_hs(h);
        repeat (3) @(negedge clka);
        total++; if ({ram[8], ram[9]} !== {32'h11111111, 32'h22222222}) begin bad++; $display("FAIL ct_ram got=%h/%h exp=11111111/22222222", ram[8], ram[9]); end
    endtask

    task automatic test_backpressure();
        int h;
        rready = 1'b0;
        araddr = 32'h10; arvalid = 1'b1;
        wait_rd_hs(h);
        repeat (2) @(negedge clka);
        start_write(32'h30, 32'h33333333, 4'hF);
        araddr = 32'h14; arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if ({rvalid, rdata} !== {1'b1, 32'hDEADAAEF}) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/deadaaef", i, rvalid, rdata); end
            total++; if ({arready, awready} !== 2'b00) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {arready, awready}); end
            @(negedge clka);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b1;
        @(negedge clka);
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", rvalid); end
    endtask

    task automatic test_reset_mid_write();
        int h;
        logic [88:0] outs;
        bready = 1'b1; rready = 1'b1;
        start_write(32'h80, 32'h12345678, 4'hF);
        wait_wr_hs(h);
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL rm_in_write got=%b exp=1", mem_en); end
        rsta = 1'b1; #1;
        outs = {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, mem_en, mem_we, mem_addr, mem_din};
        total++; if (outs !== 89'h0) begin bad++; $display("FAIL rm_outputs got=%h exp=0", outs); end
        @(negedge clka); rsta = 1'b0;
        total++; if (ram[32] !== 32'h0) begin bad++; $display("FAIL rm_no_write got=%h exp=0", ram[32]); end
        araddr = 32'h10; arvalid = 1'b1;
        wait_rd_hs(h);
        repeat (2) @(negedge clka);
        total++; if ({rvalid, rdata} !== {1'b1, 32'hDEADAAEF}) begin bad++; $display("FAIL rm_next_read got=%b/%h exp=1/deadaaef", rvalid, rdata); end
        @(negedge clka);
    endtask

    task automatic test_back_to_back();
        int h0, h1, h2;
        bready = 1'b1; rready = 1'b1;
        start_write(32'h40, 32'hA0A0A0A0, 4'hF);
        wait_wr_hs(h0);
        start_write(32'h44, 32'hB1B1B1B1, 4'hF);
        wait_wr_hs(h1);
        total++; if (h1 - h0 !== 3) begin bad++; $display("FAIL b2b_write got=%0d exp=3", h1 - h0); end
        araddr = 32'h40; arvalid = 1'b1;
        wait_rd_hs(h1);
        araddr = 32'h44; arvalid = 1'b1;
        wait_rd_hs(h2);
        total++; if (h2 - h1 !== 4) begin bad++; $display("FAIL b2b_read got=%0d exp=4", h2 - h1); end
        repeat (2) @(negedge clka);
        total++; if ({rvalid, rdata} !== {1'b1, 32'hB1B1B1B1}) begin bad++; $display("FAIL b2b_rdata got=%b/%h exp=1/b1b1b1b1", rvalid, rdata); end
        @(negedge clka);
    endtask

    task automatic test_wrap();
        int h;
        bit en_seen = 1'b0;
        bready = 1'b1; rready = 1'b1;
        start_write(32'h0, 32'hCAFEF00D, 4'hF);
        wait_wr_hs(h);
        repeat (2) @(negedge clka);
        araddr = 32'h1000; arvalid = 1'b1;
        wait_rd_hs(h);
        en_seen = mem_en;
        @(negedge clka);
        en_seen = en_seen | mem_en;
        @(negedge clka);
`ifdef AXIL_BLOCKMEM_CTRL_ERR_EN
        total++; if (en_seen !== 1'b0) begin bad++; $display("FAIL oor_mem_en got=%b exp=0", en_seen); end
        total++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b10, 32'h0}) begin bad++; $display("FAIL oor_resp got=%b/%b/%h exp=1/10/0", rvalid, rresp, rdata); end
`else
        total++; if ({en_seen, mem_addr} !== {1'b1, 10'd0}) begin bad++; $display("FAIL wrap_addr got=%b/%0d exp=1/0", en_seen, mem_addr); end
        total++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'hCAFEF00D}) begin bad++; $display("FAIL wrap_resp got=%b/%b/%h exp=1/00/cafef00d", rvalid, rresp, rdata); end
`endif
        @(negedge clka);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        test_reset();
        test_single_write();
        test_byte_readback();
        test_wstrb_zero();
        test_contention();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
